ssd_scan_ctrl: RTL
==================

Name: ssd_scan_ctrl

Overview:
Parametrised seven-segment scan controller for the Nexys 4 top levels. It replaces the fixed 8-digit hex-only scan logic. It takes a binary value (score, coordinates, debug) and shows it either in hex or in decimal. Decimal conversion uses an internal sequential double-dabble engine. Each update is atomic (no partially converted digits are ever displayed). The block also provides leading-zero blanking and per-digit decimal points, and it drives the board anodes, cathodes and Dp directly.

Parameters:
NUM_DIGITS, 8, number of physical digits scanned (1..8); sets the width of an and dp_mask.
BIN_W, 16, width of the binary input value (4..32).
SCAN_BITS, 18, dwell time per digit is 2^SCAN_BITS clk cycles (18 gives 2.62 ms at 100 MHz).

Ports:
clk  in  1  system clock (100 MHz board_clk).
reset  in  1  asynchronous, active-high reset.
value  in  BIN_W  binary value to display; sampled on load.
load  in  1  single-cycle update strobe (SCEN-style).
mode  in  1  sampled on load: 0 = hex, 1 = decimal.
blank_lz  in  1  leading-zero blanking enable (level, live).
dp_mask  in  NUM_DIGITS  dp_mask[i]=1 lights the dot on digit i (level, live).
busy  out  1  decimal conversion in progress.
overflow  out  1  last loaded value did not fit in NUM_DIGITS digits.
an  out  NUM_DIGITS  anodes, active-low, one-hot-low.
cathodes  out  7  segments {a,b,c,d,e,f,g}, active-low.
dp  out  1  decimal point, active-low.

Behaviour:
- Reset values: an all 1s, cathodes 7'b1111111, dp 1, busy 0, overflow 0, display register 0, scan counter 0, digit index 0. Reset mid-conversion aborts it; the display register still clears to 0.
- Display register: NUM_DIGITS nibbles. Digit 0 is least significant and is driven on an[0].
- Hex load (load=1, busy=0, mode=0):
  - display <= value, zero-extended or truncated to 4*NUM_DIGITS bits, on the next edge.
  - overflow <= 1 iff any truncated bit is nonzero, else 0. busy stays 0.
- Decimal load (load=1, busy=0, mode=1):
  - value and mode are latched; busy=1 from the next cycle for exactly BIN_W cycles.
  - One shift-with-add-3 iteration is done per cycle. The scratch BCD register holds DEC_DIGITS = (BIN_W*3)/10+1 digits.
  - On the cycle busy falls, the display register takes the low NUM_DIGITS BCD digits. overflow <= 1 iff any higher BCD digit is nonzero.
  - The display register is unchanged while busy=1.
- load while busy=1 is ignored (no queueing). The outputs of the running conversion are unaffected.
- Scan:
  - A free-running SCAN_BITS counter increments every cycle. On wrap, the digit index increments; it goes from NUM_DIGITS-1 back to 0, and non-power-of-2 counts are legal.
  - an, cathodes and dp are registered and reflect the index one cycle after it changes.
  - Exactly one an bit is low at all times after the first post-reset tick. an is all high until then.
- Segment encode (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Leading-zero blanking: when blank_lz=1, a digit i>0 whose nibble and all higher nibbles are 0 outputs cathodes=1111111. Its anode is still asserted. Digit 0 is never blanked, so value 0 shows a single "0".
- dp = ~dp_mask[idx]. The dot is independent of blanking.
- blank_lz and dp_mask take effect at the next registered output update (they are not sampled on load).

Optional Feature:
SSD_BLINK_EN
- Defined:
  - Adds an input blink_mask [NUM_DIGITS] and a parameter BLINK_BIT (default 25).
  - A free-running counter of BLINK_BIT+1 bits runs alongside the scan counter.
  - While counter bit BLINK_BIT = 1, any digit i with blink_mask[i]=1 outputs an=all 1s during its slot. Segment and dot values are still computed.
  - At 100 MHz this gives about 1.5 Hz blinking.
- Undefined: no port and no counter exist, and digits are never blinked.

Test Plan:
1. Reset check: SCAN_BITS=2, NUM_DIGITS=8. Assert reset, then release -> an=8'hFF until the first scan tick. After that, an walks FE, FD, FB, ... 7F, FE, changing every 4 cycles.
2. Hex load: value=16'hBEEF, mode=0, load pulse -> the next cycle display=0000BEEF and busy stays 0. Digits 3..0 show b, E, E, F. With blank_lz=1, digits 7..4 are all-off.
3. Decimal load: value=16'd65535, mode=1 -> busy high for exactly 16 cycles, display stays old throughout, then digits read 6,5,5,3,5 and overflow=0. Decimal 0 with blank_lz=1 -> only digit 0 is lit, showing 0000001.
4. Decimal overflow: NUM_DIGITS=4, value=16'd12345, mode=1 -> display 2345, overflow=1. A following hex load of 16'h00FF -> overflow=0.
5. Load during conversion: a second load at cycle 5 of busy, carrying 16'd7 -> ignored, and the first result is displayed. Reset asserted at cycle 8 of a conversion -> busy=0 and display=0 immediately.
6. Non-power-of-2 scan and dot: NUM_DIGITS=5, dp_mask=5'b00100 -> the index wraps 4 to 0, and dp=0 only while an=5'b11011. With SSD_BLINK_EN, BLINK_BIT=4 and blink_mask[0]=1 -> an[0] stays high throughout alternate 16-cycle windows.

Source files
------------

// File: rtl/ssd_scan_ctrl_if.sv
// Bus for ssd_scan_ctrl: update value/strobe and live display controls in, status and board pins out.
// blink_mask is present only when SSD_BLINK_EN is defined.
interface ssd_scan_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned BIN_W      = 16
);
   logic [BIN_W-1:0]      value;
   logic                  load;
   logic                  mode;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic                  busy;
   logic                  overflow;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            cathodes;
   logic                  dp;

`ifdef SSD_BLINK_EN
   logic [NUM_DIGITS-1:0] blink_mask;

   modport master (
      output value, load, mode, blank_lz, dp_mask, blink_mask,
      input  busy, overflow, an, cathodes, dp
   );
   modport slave (
      input  value, load, mode, blank_lz, dp_mask, blink_mask,
      output busy, overflow, an, cathodes, dp
   );
`else
   modport master (
      output value, load, mode, blank_lz, dp_mask,
      input  busy, overflow, an, cathodes, dp
   );
   modport slave (
      input  value, load, mode, blank_lz, dp_mask,
      output busy, overflow, an, cathodes, dp
   );
`endif
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: hex or double-dabble decimal display of a binary value,
// leading-zero blanking and per-digit dots. Optional digit blinking under SSD_BLINK_EN.
module ssd_scan_ctrl #(
   parameter int unsigned NUM_DIGITS = 8,
   parameter int unsigned BIN_W      = 16,
   parameter int unsigned SCAN_BITS  = 18
`ifdef SSD_BLINK_EN
   ,
   parameter int unsigned BLINK_BIT  = 25
`endif
) (
   input logic           clk,
   input logic           reset,
   ssd_scan_ctrl_if.slave bus
);
   localparam int unsigned DISP_W     = 4 * NUM_DIGITS;
   localparam int unsigned DEC_DIGITS = (BIN_W * 3) / 10 + 1;
   localparam int unsigned BCD_W      = 4 * DEC_DIGITS;
   localparam int unsigned HEX_XW     = (BIN_W > DISP_W) ? BIN_W : DISP_W;
   localparam int unsigned BCD_XW     = (BCD_W > DISP_W) ? BCD_W : DISP_W;
   localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned ITER_W     = $clog2(BIN_W + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BIN_W - 1);
   localparam logic [HEX_XW-1:0] HEX_LOW   = HEX_XW'({DISP_W{1'b1}});
   localparam logic [BCD_XW-1:0] BCD_LOW   = BCD_XW'({DISP_W{1'b1}});

   typedef enum logic {ST_IDLE, ST_CONV} state_t;

   state_t                state;
   logic [BIN_W-1:0]      bin_sr;
   logic [BCD_W-1:0]      bcd_sr;
   logic [ITER_W-1:0]     iter_cnt;
   logic [DISP_W-1:0]     display;
   logic                  busy_q;
   logic                  ovf_q;
   logic [SCAN_BITS-1:0]  scan_cnt;
   logic                  scan_run;
   logic [IDX_W-1:0]      idx;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            cath_q;
   logic                  dp_q;

   logic [BCD_W-1:0]      bcd_adj;
   logic [BCD_W-1:0]      bcd_nxt;
   logic [HEX_XW-1:0]     hex_ext;
   logic [BCD_XW-1:0]     bcd_ext;
   logic [DISP_W-1:0]     disp_hi;
   logic                  lz_off;
   logic                  blink_hide;

   function automatic logic [6:0] seg7(input logic [3:0] nib);
      case (nib)
         4'h0:    seg7 = 7'b0000001;
         4'h1:    seg7 = 7'b1001111;
         4'h2:    seg7 = 7'b0010010;
         4'h3:    seg7 = 7'b0000110;
         4'h4:    seg7 = 7'b1001100;
         4'h5:    seg7 = 7'b0100100;
         4'h6:    seg7 = 7'b0100000;
         4'h7:    seg7 = 7'b0001111;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0000100;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b1100000;
         4'hC:    seg7 = 7'b0110001;
         4'hD:    seg7 = 7'b1000010;
         4'hE:    seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary MSB
   always_comb begin
      bcd_adj = bcd_sr;
      for (int unsigned d = 0; d < DEC_DIGITS; d++) begin
         if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
      end
      bcd_nxt = BCD_W'({bcd_adj, bin_sr[BIN_W-1]});
   end

   assign hex_ext = HEX_XW'(bus.value);
   assign bcd_ext = BCD_XW'(bcd_nxt);

   // Current digit and everything above it; all-zero means a leading zero
   assign disp_hi = display >> {idx, 2'b00};
   assign lz_off  = bus.blank_lz && (idx != '0) && (disp_hi == '0);

`ifdef SSD_BLINK_EN
   logic [BLINK_BIT:0] blink_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) blink_cnt <= '0;
      else       blink_cnt <= blink_cnt + 1'b1;
   end

   assign blink_hide = blink_cnt[BLINK_BIT] && bus.blink_mask[idx];
`else
   assign blink_hide = 1'b0;
`endif

   // Load/convert FSM; display only changes on a hex load or when a conversion completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         display  <= '0;
         bin_sr   <= '0;
         bcd_sr   <= '0;
         iter_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.load) begin
                  if (bus.mode) begin
                     state    <= ST_CONV;
                     busy_q   <= 1'b1;
                     bin_sr   <= bus.value;
                     bcd_sr   <= '0;
                     iter_cnt <= '0;
                  end else begin
                     display <= hex_ext[DISP_W-1:0];
                     ovf_q   <= |(hex_ext & ~HEX_LOW);
                  end
               end
            end
            ST_CONV: begin
               bin_sr <= bin_sr << 1;
               bcd_sr <= bcd_nxt;
               if (iter_cnt == LAST_ITER) begin
                  state   <= ST_IDLE;
                  busy_q  <= 1'b0;
                  display <= bcd_ext[DISP_W-1:0];
                  ovf_q   <= |(bcd_ext & ~BCD_LOW);
               end else begin
                  iter_cnt <= iter_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Scan: the first counter wrap only arms the outputs, later wraps advance the digit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt <= '0;
         scan_run <= 1'b0;
         idx      <= '0;
         an_q     <= '1;
         cath_q   <= 7'b1111111;
         dp_q     <= 1'b1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
         if (&scan_cnt) begin
            if (!scan_run) scan_run <= 1'b1;
            else           idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         end
         if (scan_run) begin
            an_q   <= blink_hide ? '1 : ~(NUM_DIGITS'(1'b1) << idx);
            cath_q <= lz_off ? 7'b1111111 : seg7(disp_hi[3:0]);
            dp_q   <= ~bus.dp_mask[idx];
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.overflow = ovf_q;
   assign bus.an       = an_q;
   assign bus.cathodes = cath_q;
   assign bus.dp       = dp_q;
endmodule
